fetch_unit: RTL

//   Instruction-fetch stage ahead of decode/control in the pipelined RISC-V core.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the RISC-V front end.
//   XLEN             - PC / address width
//   INSTR_W          - instruction word width
//   PC_INC           - sequential fetch stride (one 32-bit word)
//   DEFAULT_RESET_PC - PC loaded on reset unless overridden
//   fetch_entry_t    - one prefetched instruction tagged with its PC
package riscv_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] PC_INC           = XLEN'(4);
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch FIFO that holds fetched instructions together with their PCs.
//   clk          in   core clock
//   rst_n        in   asynchronous active-low reset
//   push_i       in   write push_data_i at the tail (caller guarantees not full)
//   push_data_i  in   entry to write
//   pop_i        in   remove the head entry (caller guarantees not empty)
//   flush_i      in   discard all entries; overrides push and pop
//   count_o      out  number of valid entries, 0..DEPTH
//   head_o       out  entry at the read pointer
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  fetch_entry_t      push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  count_o,
  output fetch_entry_t      head_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues sequential word
// fetches to a 1-cycle-latency instruction memory, buffers responses in a
// prefetch FIFO and presents them to decode over valid/ready. A redirect
// flushes everything and restarts fetch at the (word-aligned) target.
//   clk             in   core clock
//   reset           in   asynchronous active-low reset
//   imem_req        out  fetch request this cycle
//   imem_addr       out  fetch address (word aligned)
//   imem_rdata      in   instruction word, valid the cycle after a request
//   redirect_valid  in   flush and refetch from redirect_pc
//   redirect_pc     in   redirect target
//   if_valid        out  head entry valid toward decode
//   if_ready        in   decode accepts the head this cycle
//   if_instr        out  head instruction
//   if_pc           out  head instruction's PC
module fetch_unit
  import riscv_pkg::fetch_entry_t;
  import riscv_pkg::INSTR_W;
  import riscv_pkg::PC_INC;
  import riscv_pkg::DEFAULT_RESET_PC;
#(
  parameter int                XLEN     = riscv_pkg::XLEN,
  parameter int                DEPTH    = 4,
  parameter logic [XLEN-1:0]   RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [XLEN-1:0]     if_pc
);

  localparam int              CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q,  resp_pc_d;
  logic             inflight_q, inflight_d;

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             push, pop;
  fetch_entry_t     push_entry, head;

  // Credit check: buffered plus in-flight entries must leave room for one
  // more response, so a push can never land on a full FIFO. Gating with
  // reset keeps the request low while reset is held.
  assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight_q);
  assign imem_req  = reset && !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;

  // A redirect discards the in-flight response and ignores any pop.
  assign push       = inflight_q && !redirect_valid;
  assign pop        = if_valid && if_ready && !redirect_valid;
  assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = imem_req;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
      resp_pc_d  = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC & ALIGN_MASK;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .count_o     (count),
    .head_o      (head)
  );

  assign if_valid = (count != '0);
  assign if_instr = head.instr;
  assign if_pc    = head.pc;

endmodule
